sram_req_arbiter: RTL and testbench

Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE stage data_sram interface). Requests are granted one per cycle with grant locking until address acceptance. An in-order owner FIFO tracks outstanding transactions and routes each data_ok/rdata response back to the requester that issued it. The block sits between the pipeline stages and the downstream memory bridge.

---
 rtl/sram_req_arbiter_if.sv | 19 +
 rtl/sram_req_arbiter.sv | 107 ++++++++++
 tb/tb_sram_req_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_if.sv
// sram_req_arbiter_if: SRAM-like request/response bus shared by the pipeline requesters and the memory bridge.
// Signals:
//   req/wr/size/wstrb/addr/wdata  request side, driven by the master
//   addr_ok                       request accepted this cycle, driven by the slave
//   data_ok/rdata                 in-order response, driven by the slave
// Modports: master issues requests, slave accepts them and answers.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like memory port between the inst-fetch and data requesters.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   inst_if     slave bus from the IF stage
//   data_if     slave bus from the EXE stage
//   mem_if      master bus towards the memory bridge
// Grants are locked to one requester until its address is accepted. An in-order owner FIFO
// routes each data_ok/rdata back to the requester that issued the transaction.
// Define ARB_RR_EN for round-robin priority; otherwise data always wins over inst.
module sram_req_arbiter #(
    parameter int OUTST_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    sram_req_arbiter_if.slave   inst_if,
    sram_req_arbiter_if.slave   data_if,
    sram_req_arbiter_if.master  mem_if
);
    localparam int AW = $clog2(OUTST_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUTST_DEPTH-1:0] owner_q, owner_d;
    logic                   gnt, sel_req, full, push, pop, head, conflict_pick;

`ifdef ARB_RR_EN
    logic last_q, last_d;
    // On conflict the requester not served last time wins.
    assign conflict_pick = ~last_q;
    assign last_d        = push ? gnt : last_q;
`else
    assign conflict_pick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef ARB_RR_EN
            last_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    // Owner bits are only read behind a nonzero count, so they need no reset.
    always_ff @(posedge clk) begin
        owner_q <= owner_d;
    end

    // A locked state stays put while its requester keeps asking and is not accepted;
    // a dropped request abandons the lock.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (mem_if.req & ~mem_if.addr_ok) ? (gnt ? LOCK_D : LOCK_I) : IDLE;
        else
            state_d = (~sel_req | push) ? IDLE : state_q;
    end

    // Owner FIFO: 0 = inst, 1 = data. Full blocks the push, so push and pop together never overflow.
    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        owner_d  = owner_q;
        if (push)
            owner_d[wr_ptr_q] = gnt;
    end

    // Grant select, memory mux and response routing; everything reads 0 while reset is high.
    always_comb begin
        gnt             = (state_q == LOCK_D) |
                          ((state_q == IDLE) & data_if.req & (~inst_if.req | conflict_pick));
        sel_req         = gnt ? data_if.req : inst_if.req;
        full            = count_q == CW'(OUTST_DEPTH);
        mem_if.req      = ~reset & ~full & sel_req;
        mem_if.wr       = ~reset & (gnt ? data_if.wr : inst_if.wr);
        mem_if.size     = reset ? '0 : (gnt ? data_if.size : inst_if.size);
        mem_if.wstrb    = reset ? '0 : (gnt ? data_if.wstrb : inst_if.wstrb);
        mem_if.addr     = reset ? '0 : (gnt ? data_if.addr : inst_if.addr);
        mem_if.wdata    = reset ? '0 : (gnt ? data_if.wdata : inst_if.wdata);
        push            = mem_if.req & mem_if.addr_ok;
        // A response with nothing outstanding is a stray and is dropped.
        pop             = ~reset & mem_if.data_ok & (count_q != '0);
        head            = owner_q[rd_ptr_q];
        inst_if.addr_ok = push & ~gnt;
        data_if.addr_ok = push & gnt;
        inst_if.data_ok = pop & ~head;
        data_if.data_ok = pop & head;
        inst_if.rdata   = reset ? '0 : mem_if.rdata;
        data_if.rdata   = reset ? '0 : mem_if.rdata;
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed and random checks of sram_req_arbiter against a queue-based model.
module tb_sram_req_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_req_arbiter_if inst_bus ();
    sram_req_arbiter_if data_bus ();
    sram_req_arbiter_if mem_bus ();

    sram_req_arbiter #(.OUTST_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .inst_if(inst_bus),
        .data_if(data_bus),
        .mem_if (mem_bus)
    );

    int total = 0;
    int bad = 0;

    // Model: queue of owners in issue order (0 = inst, 1 = data), lock holder (0 none, 1 inst, 2 data).
    bit oq[$];
    int lock = 0;
    bit last = 1'b0;
    bit acc_i, acc_d;

    logic [31:0] ia, da, iwd, dwd;
    logic        iw, dw;
    logic [1:0]  isz, dsz;
    logic [3:0]  ist, dst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic mao, input logic mdo, input logic [31:0] rd);
        inst_bus.req = ir;  inst_bus.wr = iw;  inst_bus.size = isz;  inst_bus.wstrb = ist;
        inst_bus.addr = ia; inst_bus.wdata = iwd;
        data_bus.req = dr;  data_bus.wr = dw;  data_bus.size = dsz;  data_bus.wstrb = dst;
        data_bus.addr = da; data_bus.wdata = dwd;
        mem_bus.addr_ok = mao; mem_bus.data_ok = mdo; mem_bus.rdata = rd;
    endtask

    task automatic step(input logic ir, input logic dr, input logic mao, input logic mdo, input logic [31:0] rd);
        bit g, exp_req, acc, pop, own;
        drive(ir, dr, mao, mdo, rd);
        if (lock == 1) g = 1'b0;
        else if (lock == 2) g = 1'b1;
`ifdef ARB_RR_EN
        else if (ir && dr) g = ~last;
`else
        else if (ir && dr) g = 1'b1;
`endif
        else g = dr;
        exp_req = (oq.size() < DEPTH) && (g ? dr : ir);
        acc     = exp_req && mao;
        pop     = mdo && (oq.size() > 0);
        own     = pop ? oq[0] : 1'b0;
        @(negedge clk);
        chk("mem_req", 32'(mem_bus.req), 32'(exp_req));
        chk("inst_addr_ok", 32'(inst_bus.addr_ok), 32'(acc && !g));
        chk("data_addr_ok", 32'(data_bus.addr_ok), 32'(acc && g));
        chk("inst_data_ok", 32'(inst_bus.data_ok), 32'(pop && !own));
        chk("data_data_ok", 32'(data_bus.data_ok), 32'(pop && own));
        chk("inst_rdata", inst_bus.rdata, rd);
        chk("data_rdata", data_bus.rdata, rd);
        if (exp_req) begin
            chk("mem_addr", mem_bus.addr, g ? da : ia);
            chk("mem_wdata", mem_bus.wdata, g ? dwd : iwd);
            chk("mem_ctl", {25'd0, mem_bus.wr, mem_bus.size, mem_bus.wstrb}, g ? {25'd0, dw, dsz, dst} : {25'd0, iw, isz, ist});
        end
        if (pop) void'(oq.pop_front());
        if (acc) oq.push_back(g);
        if (lock == 0) begin
            if (exp_req && !acc) lock = g ? 2 : 1;
        end else if (!(g ? dr : ir) || acc) lock = 0;
        if (acc) last = g;
        acc_i = acc && !g;
        acc_d = acc && g;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_bus.req), 32'd0);
        chk("rst_addr_ok", {30'd0, inst_bus.addr_ok, data_bus.addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, inst_bus.data_ok, data_bus.data_ok}, 32'd0);
        chk("rst_inst_rdata", inst_bus.rdata, 32'd0);
        chk("rst_data_rdata", data_bus.rdata, 32'd0);
        chk("rst_mem_addr", mem_bus.addr, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        oq.delete();
        lock = 0;
        last = 1'b0;
        chk("rst_count", 32'(dut.count_q), 32'd0);
    endtask

    initial begin
        bit ip, dp;
        ia = 32'h100; da = 32'h200; iwd = 0; dwd = 32'h55; iw = 0; dw = 1; isz = 2; dsz = 2; ist = 4'hF; dst = 4'h3;
        rst_step();

        // Stray response with nothing outstanding.
        step(0, 0, 0, 1, 32'h1);
        chk("stray_count", 32'(dut.count_q), 32'd0);

        // Conflict: both requesting, accepted two cycles in a row.
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 32'h11);
        step(0, 0, 0, 1, 32'h22);

        // Lock hold on data at 0x1000 while inst rises.
        da = 32'h1000;
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("lock_addr", mem_bus.addr, 32'h1000);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("lock_accept_d", 32'(acc_d), 32'd1);
        step(1, 0, 1, 0, 0);
        chk("lock_then_i", 32'(acc_i), 32'd1);
        step(0, 0, 0, 1, 32'h33);
        step(0, 0, 0, 1, 32'h44);

        // Full: four inst reads outstanding, the fifth waits for a response.
        for (int i = 0; i < 4; i++) begin
            ia = 32'h2000 + 32'(i * 4);
            step(1, 0, 1, 0, 0);
        end
        chk("full_count", 32'(dut.count_q), 32'd4);
        ia = 32'h2010;
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 32'h77);
        step(1, 0, 1, 0, 0);
        chk("full_fifth_acc", 32'(acc_i), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'(i));
        chk("drain_count", 32'(dut.count_q), 32'd0);

        // Ordering: inst, data, inst answered with A, B, C.
        step(1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 32'hA);
        step(0, 0, 0, 1, 32'hB);
        step(0, 0, 0, 1, 32'hC);

        // Reset with two outstanding and data locked.
        step(1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        rst_step();
        step(0, 0, 0, 1, 32'hE);
        step(1, 0, 1, 0, 0);
        chk("post_rst_inst", 32'(acc_i), 32'd1);
        step(0, 0, 0, 1, 32'hF);

        // Random traffic with requests held until accepted.
        ip = 0;
        dp = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!ip) begin
                ip = $urandom_range(0, 2) != 0;
                ia = $urandom; iwd = $urandom; iw = 1'($urandom); isz = 2'($urandom); ist = 4'($urandom);
            end
            if (!dp) begin
                dp = $urandom_range(0, 2) != 0;
                da = $urandom; dwd = $urandom; dw = 1'($urandom); dsz = 2'($urandom); dst = 4'($urandom);
            end
            step(ip, dp, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
            if (acc_i) ip = 0;
            if (acc_d) dp = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
